// File: rtl/mem_pkg.sv
// Shared types for the sized data memory: access-size encoding, FSM states, helpers.
package mem_pkg;

  localparam int unsigned WORD_SIZE = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_e;

  // Number of cells touched by an access; reserved size reports 0.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_bytes = 3'd1;
      MEM_HALF: size_bytes = 3'd2;
      MEM_WORD: size_bytes = 3'd4;
      default:  size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/response bus between a requester (master) and the data memory (slave).
interface data_mem_sized_if;

  logic                           req_valid;
  logic                           req_ready;
  logic                           req_write;
  logic [1:0]                     req_size;
  logic                           req_unsigned;
  logic [mem_pkg::WORD_SIZE-1:0]  addr;
  logic [mem_pkg::WORD_SIZE-1:0]  data_in;
  logic                           resp_valid;
  logic [mem_pkg::WORD_SIZE-1:0]  data_out;
  logic                           resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, addr, data_in,
    input  req_ready, resp_valid, data_out, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, addr, data_in,
    output req_ready, resp_valid, data_out, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Load lane selection: picks the addressed byte/half out of a big-endian word
// and sign- or zero-extends it to the full word width.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned CELL_W = 8
) (
  input  logic [4*CELL_W-1:0]  word,
  input  logic [1:0]           lane,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  output logic [WORD_SIZE-1:0] result
);

  logic [CELL_W-1:0]   byte_v;
  logic [2*CELL_W-1:0] half_v;

  // Lane 0 is the lowest address, which sits in the most significant cell.
  always_comb begin
    byte_v = '0;
    half_v = '0;
    result = '0;
    case (lane)
      2'd0:    byte_v = word[4*CELL_W-1:3*CELL_W];
      2'd1:    byte_v = word[3*CELL_W-1:2*CELL_W];
      2'd2:    byte_v = word[2*CELL_W-1:CELL_W];
      default: byte_v = word[CELL_W-1:0];
    endcase
    half_v = lane[1] ? word[2*CELL_W-1:0] : word[4*CELL_W-1:2*CELL_W];
    case (size)
      MEM_BYTE: result = is_unsigned ? WORD_SIZE'(byte_v) : WORD_SIZE'($signed(byte_v));
      MEM_HALF: result = is_unsigned ? WORD_SIZE'(half_v) : WORD_SIZE'($signed(half_v));
      MEM_WORD: result = WORD_SIZE'(word);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed, big-endian data memory with byte/half/word accesses.
// Memory self-clears one word per cycle after reset before accepting requests.
module data_mem_sized
  import mem_pkg::*;
#(
  parameter int unsigned          MEM_CELL_SIZE = 8,
  parameter int unsigned          DATA_MEM_SIZE = 1024,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR     = 32'h0000_0400
) (
  input logic             clk,
  input logic             rst,
  data_mem_sized_if.slave bus
);

  localparam int unsigned CELL   = MEM_CELL_SIZE;
  localparam int unsigned AW     = $clog2(DATA_MEM_SIZE);
  localparam int unsigned CW     = AW - 2;
  localparam int unsigned NWORDS = DATA_MEM_SIZE / 4;
  localparam int unsigned EW     = WORD_SIZE + 1;

  logic [CELL-1:0] mem [DATA_MEM_SIZE];

  mem_state_e           state;
  logic [CW-1:0]        clr_cnt;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [WORD_SIZE-1:0] data_out_q;

  logic                 accept;
  logic                 req_err;
  logic [WORD_SIZE-1:0] offset;
  logic [EW-1:0]        end_off;
  logic [AW-1:0]        idx;
  logic [AW-3:0]        wi;
  logic [4*CELL-1:0]    rd_word;
  logic [WORD_SIZE-1:0] load_data;

  // Request decode: range/alignment check and read of the containing word.
  always_comb begin
    accept  = bus.req_valid && (state == RUN) && !rst;
    offset  = bus.addr - BASE_ADDR;
    end_off = {1'b0, offset} + EW'(size_bytes(bus.req_size));
    req_err = (bus.addr < BASE_ADDR)
           || (end_off > EW'(DATA_MEM_SIZE))
           || (bus.req_size == MEM_RSVD)
           || ((bus.req_size == MEM_HALF) && offset[0])
           || ((bus.req_size == MEM_WORD) && (offset[1:0] != 2'b00));
    idx     = offset[AW-1:0];
    wi      = idx[AW-1:2];
    rd_word = {mem[{wi, 2'b00}], mem[{wi, 2'b01}], mem[{wi, 2'b10}], mem[{wi, 2'b11}]};
  end

  mem_lane_align #(.CELL_W(CELL)) u_lane_align (
    .word       (rd_word),
    .lane       (idx[1:0]),
    .size       (bus.req_size),
    .is_unsigned(bus.req_unsigned),
    .result     (load_data)
  );

  // State machine, clear counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      data_out_q   <= '0;
    end else begin
      resp_valid_q <= accept;
      resp_err_q   <= accept && req_err;
      data_out_q   <= (accept && !req_err && !bus.req_write) ? load_data : '0;
      if (state == CLEAR) begin
        if (clr_cnt == CW'(NWORDS - 1)) state <= RUN;
        clr_cnt <= clr_cnt + CW'(1);
      end
    end
  end

  // Storage: zero one word per cycle while clearing, else apply valid stores.
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) begin
      for (int k = 0; k < 4; k++) mem[{clr_cnt, 2'(k)}] <= '0;
    end else if (accept && !req_err && bus.req_write) begin
      case (bus.req_size)
        MEM_BYTE: mem[idx] <= bus.data_in[CELL-1:0];
        MEM_HALF: begin
          mem[{idx[AW-1:1], 1'b0}] <= bus.data_in[2*CELL-1:CELL];
          mem[{idx[AW-1:1], 1'b1}] <= bus.data_in[CELL-1:0];
        end
        MEM_WORD: begin
          mem[{wi, 2'b00}] <= bus.data_in[4*CELL-1:3*CELL];
          mem[{wi, 2'b01}] <= bus.data_in[3*CELL-1:2*CELL];
          mem[{wi, 2'b10}] <= bus.data_in[2*CELL-1:CELL];
          mem[{wi, 2'b11}] <= bus.data_in[CELL-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == RUN);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized: a byte-array reference model predicts
// each response when the request is driven; a monitor pops and compares.
module tb_data_mem_sized;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_sized_if bus ();

  data_mem_sized #(
    .MEM_CELL_SIZE(8),
    .DATA_MEM_SIZE(1024),
    .BASE_ADDR    (32'h0000_0400)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [7:0]  model[1024];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
    longint off;
    longint sb;
    if (a < 32'h400) return 1'b1;
    if (sz == 2'b11) return 1'b1;
    off = longint'(a) - 64'h400;
    sb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (off + sb > 1024) return 1'b1;
    if (sz == 2'b01 && off[0]) return 1'b1;
    if (sz == 2'b10 && off[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    int          off;
    logic [7:0]  b;
    logic [15:0] h;
    off = int'(a - 32'h400);
    case (sz)
      2'b00: begin
        b = model[off];
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        h = {model[off], model[off+1]};
        return uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {model[off], model[off+1], model[off+2], model[off+3]};
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int off;
    off = int'(a - 32'h400);
    case (sz)
      2'b00: model[off] = d[7:0];
      2'b01: begin
        model[off]   = d[15:8];
        model[off+1] = d[7:0];
      end
      default: begin
        model[off]   = d[31:24];
        model[off+1] = d[23:16];
        model[off+2] = d[15:8];
        model[off+3] = d[7:0];
      end
    endcase
  endtask

  // Drive one request (held for one cycle) and push its predicted response.
  task automatic issue(input bit w, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit has_lit = 1'b0, input logic [31:0] lit = 32'h0);
    bit          e;
    logic [31:0] ed;
    @(negedge clk);
    check("ready", 64'(bus.req_ready), 64'(1));
    e  = ref_err(sz, a);
    ed = 32'h0;
    if (!e && !w) ed = has_lit ? lit : ref_load(sz, uns, a);
    if (!e && w) ref_store(sz, a, d);
    exp_q.push_back({e, ed});
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.addr         = a;
    bus.data_in      = d;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Reset for one edge; with keep_valid a load is presented on the reset edge.
  task automatic do_reset(input bit keep_valid);
    int lows;
    @(negedge clk);
    rst = 1'b1;
    if (keep_valid) bus.req_write = 1'b0;
    else bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_ready", 64'(bus.req_ready), 64'(0));
    check("rst_resp", 64'({bus.resp_valid, bus.resp_err, bus.data_out}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    lows = 0;
    while (bus.req_ready !== 1'b1 && lows < 2000) begin
      lows++;
      @(negedge clk);
    end
    check("clear_cycles", 64'(lows), 64'(256));
  endtask

  // Response monitor: compare every response, require zeros when idle.
  initial begin
    logic [32:0] x;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (bus.resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'({bus.resp_err, bus.data_out}), 64'hDEAD_0000_0000_0000);
        end else begin
          x = exp_q.pop_front();
          check("resp", {31'b0, bus.resp_err, bus.data_out}, 64'(x));
        end
      end else begin
        check("idle_zero", 64'({bus.resp_valid, bus.resp_err, bus.data_out}), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.addr         = 32'h0;
    bus.data_in      = 32'h0;

    do_reset(1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0000_0000);

    // Word store then per-byte big-endian loads.
    issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEAD_BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 1'b1, 32'hFFFF_FFDE);
    issue(1'b0, 2'b00, 1'b0, 32'h401, 32'h0, 1'b1, 32'hFFFF_FFAD);
    issue(1'b0, 2'b00, 1'b0, 32'h402, 32'h0, 1'b1, 32'hFFFF_FFBE);
    issue(1'b0, 2'b00, 1'b0, 32'h403, 32'h0, 1'b1, 32'hFFFF_FFEF);
    issue(1'b0, 2'b00, 1'b1, 32'h401, 32'h0, 1'b1, 32'h0000_00AD);

    // Half store merges into the word.
    issue(1'b1, 2'b01, 1'b0, 32'h402, 32'h0000_1234);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'hDEAD_1234);
    issue(1'b0, 2'b01, 1'b0, 32'h400, 32'h0, 1'b1, 32'hFFFF_DEAD);
    issue(1'b0, 2'b01, 1'b1, 32'h402, 32'h0, 1'b1, 32'h0000_1234);
    idle(2);

    // Rejected accesses leave memory unchanged.
    issue(1'b0, 2'b10, 1'b0, 32'h401, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h403, 32'hFFFF_FFFF);
    issue(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h1111_1111);
    issue(1'b1, 2'b10, 1'b0, 32'h800, 32'h2222_2222);
    issue(1'b1, 2'b11, 1'b0, 32'h400, 32'h3333_3333);
    issue(1'b0, 2'b11, 1'b0, 32'h400, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'hDEAD_1234);

    // Store immediately followed by a load of the same top word.
    issue(1'b1, 2'b10, 1'b0, 32'h7FC, 32'hCAFE_F00D);
    issue(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 1'b1, 32'hCAFE_F00D);

    // Upper/lower range edges.
    issue(1'b0, 2'b00, 1'b1, 32'h7FF, 32'h0, 1'b1, 32'h0000_000D);
    issue(1'b0, 2'b01, 1'b0, 32'h7FE, 32'h0, 1'b1, 32'hFFFF_F00D);
    issue(1'b0, 2'b01, 1'b0, 32'h7FF, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h800, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    idle(2);

    // Random traffic around both ends of the window.
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = (i % 2 == 0) ? 32'h3F8 + 32'($urandom_range(0, 40))
                       : 32'h7D8 + 32'($urandom_range(0, 48));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom());
      if (i % 17 == 16) idle(1);
    end
    idle(3);

    // Reset during traffic: the request on the reset edge gets no response.
    issue(1'b1, 2'b10, 1'b0, 32'h500, 32'h1122_3344);
    do_reset(1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 1'b1, 32'h0000_0000);
    issue(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 1'b1, 32'h0000_0000);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0000_0000);
    idle(3);

    check("drain", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 The block SHALL have parameter MEM_CELL_SIZE, default 8, width in bits of one memory cell (byte).
REQ-002 The block SHALL have parameter DATA_MEM_SIZE, default 1024, number of cells; a multiple of 4.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0400, byte address of cell 0.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port req_valid  input  1  request present.
REQ-007 The block SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-008 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 The block SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 The block SHALL have port req_unsigned  input  1  loads zero-extend when 1, sign-extend when 0.
REQ-011 The block SHALL have port addr  input  `WORD_SIZE  byte address.
REQ-012 The block SHALL have port data_in  input  `WORD_SIZE  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 The block SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-014 The block SHALL have port data_out  output  `WORD_SIZE  load result, right-aligned and extended.
REQ-015 The block SHALL have port resp_err  output  1  access rejected (qualifies resp_valid).

Function
REQ-016 Storage SHALL be big-endian: the byte at the lowest address is the MSB of a word, matching the existing data memory layout.
REQ-017 State machine SHALL have two states: CLEAR (zeroing memory) and RUN; req_ready = (state == RUN).
REQ-018 In CLEAR, a counter SHALL zero one 4-cell word per cycle, from word 0 upward; after word DATA_MEM_SIZE/4-1 it SHALL go to RUN (DATA_MEM_SIZE/4 cycles total).
REQ-019 A request SHALL be accepted on a rising edge with req_valid && req_ready; one request per cycle, no bubbles.
REQ-020 Every accepted request, load or store, SHALL produce resp_valid high for exactly the single following cycle; there is no response back-pressure.
REQ-021 Offset = addr - BASE_ADDR; the request SHALL be errored when addr < BASE_ADDR, offset + size_bytes > DATA_MEM_SIZE, req_size = 11, half with offset[0]=1, or word with offset[1:0]!=0.
REQ-022 An errored request SHALL not modify memory; its response SHALL carry resp_err=1, data_out=0.
REQ-023 A store SHALL write only the 1, 2 or 4 addressed cells at the accept edge; other cells SHALL be unchanged.
REQ-024 A load SHALL return registered data one cycle after acceptance: byte/half extended per req_unsigned; word unchanged.
REQ-025 A load accepted the cycle after a store to the same address SHALL return the newly stored data.
REQ-026 data_out SHALL be 0 and resp_err SHALL be 0 whenever resp_valid is 0.

Reset
REQ-027 rst high at a rising edge SHALL force state CLEAR, counter 0, resp_valid=0, resp_err=0, data_out=0, req_ready=0 from the next cycle.
REQ-028 rst asserted mid-CLEAR or mid-traffic SHALL restart clearing from word 0; an in-flight response SHALL be dropped.
REQ-029 Memory contents SHALL be all zero once req_ready first rises after reset.

Structure
REQ-030 A shared package mem_pkg SHALL hold the size encoding (MEM_BYTE, MEM_HALF, MEM_WORD) and the state enum (CLEAR, RUN).
REQ-031 A combinational sub-module mem_lane_align SHALL perform load byte/half selection and sign/zero extension.
REQ-032 No other sub-modules; the storage array SHALL remain inside data_mem_sized.

Verification
REQ-033 Reset then idle -> req_ready low for exactly 256 cycles (default parameters), then high; word load at 0x400 returns 0x00000000.
REQ-034 Word store 0xDEADBEEF at 0x400, then byte loads at 0x400..0x403 -> 0xFFFFFFDE, 0xFFFFFFAD, 0xFFFFFFBE, 0xFFFFFFEF; unsigned byte at 0x401 -> 0x000000AD.
REQ-035 Half store 0x1234 at 0x402 over that word -> word load 0xDEAD1234; signed half load at 0x400 -> 0xFFFFDEAD.
REQ-036 Word load at 0x401, half store at 0x403, word access at 0x3FC and 0x800, size 11 -> resp_err=1, data_out=0; memory unchanged.
REQ-037 Back-to-back store 0xCAFEF00D then load at 0x7FC -> load response next cycle equals 0xCAFEF00D; resp_valid high on both consecutive cycles.
REQ-038 rst pulsed during traffic with a response pending -> resp_valid stays 0, req_ready low 256 cycles, previously written words read 0.
